// File: rtl/cmp_arbiter.sv
// Two-port round-robin arbiter in front of a shared 64-bit compare datapath
// with a single registered, held response channel. Optional counters: CMP_ARB_PERF_EN.
module cmp_arbiter #(
    parameter int unsigned XLEN         = 64,
    parameter bit          RR_RESET_PTR = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic [2:0]      req0_funct3,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic [2:0]      req1_funct3,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic            rsp_cond,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_eq,
`ifdef CMP_ARB_PERF_EN
    output logic            rsp_illegal,
    output logic [31:0]     perf_grant0,
    output logic [31:0]     perf_grant1,
    output logic [31:0]     perf_conflict
`else
    output logic            rsp_illegal
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic rr_ptr_q, rr_ptr_d;
    logic id_q, id_d;
    logic cond_q, cond_d;
    logic eq_q, eq_d;
    logic illegal_q, illegal_d;

    logic            can_accept;
    logic            both_valid;
    logic            do_grant;
    logic            grant_id;
    logic [XLEN-1:0] sel_op1;
    logic [XLEN-1:0] sel_op2;
    logic [2:0]      sel_funct3;
    logic            cmp_eq;
    logic            cmp_ult;
    logic            cmp_slt;
    logic            eval_cond;
    logic            eval_illegal;

    // A single valid requester always wins; rr_ptr only breaks ties.
    always_comb begin
        can_accept = !flush && ((state_q == EMPTY) || rsp_ready);
        both_valid = req0_valid && req1_valid;
        grant_id   = both_valid ? rr_ptr_q : req1_valid;
        do_grant   = can_accept && (req0_valid || req1_valid);
        req0_ready = do_grant && !grant_id;
        req1_ready = do_grant && grant_id;
    end

    always_comb begin
        sel_op1    = grant_id ? req1_op1 : req0_op1;
        sel_op2    = grant_id ? req1_op2 : req0_op2;
        sel_funct3 = grant_id ? req1_funct3 : req0_funct3;
        cmp_eq     = (sel_op1 == sel_op2);
        cmp_ult    = (sel_op1 < sel_op2);
        // Differing sign bits decide a signed compare; otherwise unsigned order holds.
        cmp_slt    = (sel_op1[XLEN-1] != sel_op2[XLEN-1]) ? sel_op1[XLEN-1] : cmp_ult;
        eval_cond    = 1'b0;
        eval_illegal = 1'b0;
        case (sel_funct3)
            3'b000:  eval_cond = cmp_eq;
            3'b001:  eval_cond = !cmp_eq;
            3'b100:  eval_cond = cmp_slt;
            3'b101:  eval_cond = !cmp_slt;
            3'b110:  eval_cond = cmp_ult;
            3'b111:  eval_cond = !cmp_ult;
            default: eval_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        cond_d    = cond_q;
        eq_d      = eq_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (do_grant) begin
            state_d   = HELD;
            rr_ptr_d  = !grant_id;
            id_d      = grant_id;
            cond_d    = eval_cond;
            eq_d      = cmp_eq;
            illegal_d = eval_illegal;
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= EMPTY;
            rr_ptr_q  <= RR_RESET_PTR;
            id_q      <= 1'b0;
            cond_q    <= 1'b0;
            eq_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            cond_q    <= cond_d;
            eq_q      <= eq_d;
            illegal_q <= illegal_d;
        end
    end

    assign rsp_valid   = (state_q == HELD);
    assign rsp_id      = id_q;
    assign rsp_cond    = cond_q;
    assign rsp_eq      = eq_q;
    assign rsp_illegal = illegal_q;
    assign rsp_result  = {{(XLEN-1){1'b0}}, cond_q};

`ifdef CMP_ARB_PERF_EN
    logic [31:0] grant0_q, grant1_q, conflict_q;

    // Both valid means either no grant or one requester loses: counted either way.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant0_q   <= '0;
            grant1_q   <= '0;
            conflict_q <= '0;
        end else begin
            if (req0_ready && (grant0_q != '1)) grant0_q <= grant0_q + 32'd1;
            if (req1_ready && (grant1_q != '1)) grant1_q <= grant1_q + 32'd1;
            if (both_valid && (conflict_q != '1)) conflict_q <= conflict_q + 32'd1;
        end
    end

    assign perf_grant0   = grant0_q;
    assign perf_grant1   = grant1_q;
    assign perf_conflict = conflict_q;
`endif

endmodule
